// File: rtl/spi_master_shifter_pkg.sv
// Shared definitions for the SPI master shift engine.
package spi_pkg;

  // Default maximum transfer length in bits.
  localparam int SPI_DATA_W = 32;

  // Shift engine states.
  typedef enum logic [1:0] {
    SHIFT_IDLE  = 2'd0,
    SHIFT_SHIFT = 2'd1,
    SHIFT_DRAIN = 2'd2,
    SHIFT_RXOUT = 2'd3
  } spi_shift_state_e;

endpackage

// File: rtl/spi_master_shifter_if.sv
// Bundles the word handshakes, clock-generator strobes and serial lines of
// the shift engine. The engine uses the slave view and its driver the master view.
interface spi_master_shifter_if
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W,
  parameter int LEN_W  = $clog2(DATA_W)
);

  logic [DATA_W-1:0] tx_data;
  logic [LEN_W-1:0]  len_m1;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              spi_rise;
  logic              spi_fall;
  logic              clk_en;
  logic              sdo;
  logic              sdi;
  logic              busy;

  modport slave (
    input  tx_data, len_m1, tx_valid, rx_ready, spi_rise, spi_fall, sdi,
    output tx_ready, rx_data, rx_valid, clk_en, sdo, busy
  );

  modport master (
    output tx_data, len_m1, tx_valid, rx_ready, spi_rise, spi_fall, sdi,
    input  tx_ready, rx_data, rx_valid, clk_en, sdo, busy
  );

endinterface

// File: rtl/spi_master_shifter.sv
// SPI mode 0, MSB-first shift engine. Serialises one word onto sdo and
// collects sdi into one word per transfer, pacing itself on the rise/fall
// strobes of the SPI clock generator that it gates through clk_en.
module spi_master_shifter
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W,
  parameter int LEN_W  = $clog2(DATA_W)
) (
  input  logic                clk,
  input  logic                rst,
  spi_master_shifter_if.slave bus
);

  localparam logic [1:0] S_IDLE  = SHIFT_IDLE;
  localparam logic [1:0] S_SHIFT = SHIFT_SHIFT;
  localparam logic [1:0] S_DRAIN = SHIFT_DRAIN;
  localparam logic [1:0] S_RXOUT = SHIFT_RXOUT;

  logic [1:0]        state_q,     state_d;
  logic [DATA_W-1:0] tx_sreg_q,   tx_sreg_d;
  logic [DATA_W-1:0] rx_sreg_q,   rx_sreg_d;
  logic [LEN_W-1:0]  bits_left_q, bits_left_d;
  logic              sdo_q,       sdo_d;

  // Next-state logic: handshake capture, bit counting and both shift registers.
  always_comb begin
    state_d     = state_q;
    tx_sreg_d   = tx_sreg_q;
    rx_sreg_d   = rx_sreg_q;
    bits_left_d = bits_left_q;
    sdo_d       = sdo_q;

    case (state_q)
      S_IDLE: begin
        if (bus.tx_valid) begin
          // The first bit goes out immediately so it is settled before the first rise.
          tx_sreg_d   = bus.tx_data;
          bits_left_d = bus.len_m1;
          rx_sreg_d   = '0;
          sdo_d       = bus.tx_data[bus.len_m1];
          state_d     = S_SHIFT;
        end
      end

      S_SHIFT: begin
        // A rise takes priority; a simultaneous fall is dropped.
        if (bus.spi_rise) begin
          rx_sreg_d = {rx_sreg_q[DATA_W-2:0], bus.sdi};
          if (bits_left_q == '0) begin
            state_d = S_DRAIN;
          end else begin
            bits_left_d = bits_left_q - LEN_W'(1);
          end
        end else if (bus.spi_fall) begin
          // bits_left already points at the next lower bit after the rise.
          sdo_d = tx_sreg_q[bits_left_q];
        end
      end

      S_DRAIN: begin
        // Wait for the generator's trailing fall; the last bit stays on sdo.
        if (bus.spi_fall && !bus.spi_rise) begin
          state_d = S_RXOUT;
        end
      end

      S_RXOUT: begin
        if (bus.rx_ready) begin
          state_d = S_IDLE;
          sdo_d   = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      tx_sreg_q   <= '0;
      rx_sreg_q   <= '0;
      bits_left_q <= '0;
      sdo_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_sreg_q   <= tx_sreg_d;
      rx_sreg_q   <= rx_sreg_d;
      bits_left_q <= bits_left_d;
      sdo_q       <= sdo_d;
    end
  end

  // Outputs decode directly from registered state, so reset drops clk_en on the same edge.
  assign bus.tx_ready = (state_q == S_IDLE);
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.clk_en   = (state_q == S_SHIFT);
  assign bus.rx_valid = (state_q == S_RXOUT);
  assign bus.rx_data  = rx_sreg_q;
  assign bus.sdo      = sdo_q;

endmodule

// File: tb/tb_spi_master_shifter.sv
// Self-checking bench for spi_master_shifter with a behavioural SPI clock
// generator, table-driven transfers, randomised transfers and corner sequences.
module tb_spi_master_shifter;
  import spi_pkg::*;

  localparam int DW = SPI_DATA_W;
  localparam int LW = $clog2(DW);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_master_shifter_if #(.DATA_W(DW), .LEN_W(LW)) bus ();

  spi_master_shifter #(.DATA_W(DW), .LEN_W(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Generator model state
  int          gen_div = 1;
  int          gen_cnt = 0;
  bit          sclk = 1'b0;
  bit          inj_rise = 1'b0, inj_fall = 1'b0, inj_active = 1'b0;
  bit          trail_pending = 1'b0;
  int          sdi_mode = 0;     // 0: sdi=0, 1: sdi=1, 2: loopback, 3: random word
  logic [31:0] sdi_word = '0;
  int          cur_lm1 = 0;

  // Observations of the current transfer
  int          rise_cnt, trail_cnt;
  logic [31:0] sdo_word;
  logic        en_after_last, sdo_before_trail, sdo_after_trail, rxv_after_trail;

  typedef struct {
    logic [31:0] data;
    int          lm1;
    int          mode;
    int          div;
    logic [31:0] exp_rx;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // One system clock: lets the DUT consume the current strobes, then runs
  // the generator model at the falling edge to present the next ones.
  task automatic tick();
    logic pr, pf;
    bit was_trail, was_inj;
    pr        = bus.spi_rise;
    pf        = bus.spi_fall;
    was_trail = trail_pending;
    was_inj   = inj_active;
    @(negedge clk);
    if (!was_inj) begin
      if (pr) sclk = 1'b1;
      if (pf) sclk = 1'b0;
    end
    if (pr && !was_inj && rise_cnt == cur_lm1 + 1) en_after_last = bus.clk_en;
    if (pf && was_trail) begin
      trail_cnt++;
      sdo_after_trail = bus.sdo;
      rxv_after_trail = bus.rx_valid;
    end
    bus.spi_rise  = 1'b0;
    bus.spi_fall  = 1'b0;
    trail_pending = 1'b0;
    inj_active    = 1'b0;
    if (rst) begin
      sclk    = 1'b0;
      gen_cnt = 0;
    end else if (bus.clk_en || sclk) begin
      if (gen_cnt >= gen_div - 1) begin
        gen_cnt = 0;
        if (sclk) begin
          bus.spi_fall = 1'b1;
          if (!bus.clk_en) begin
            trail_pending    = 1'b1;
            sdo_before_trail = bus.sdo;
          end
        end else begin
          bus.spi_rise = 1'b1;
          case (sdi_mode)
            0:       bus.sdi = 1'b0;
            1:       bus.sdi = 1'b1;
            2:       bus.sdi = bus.sdo;
            default: bus.sdi = (rise_cnt <= cur_lm1) ? sdi_word[cur_lm1 - rise_cnt] : 1'b0;
          endcase
          sdo_word = {sdo_word[30:0], bus.sdo};
          rise_cnt++;
        end
      end else begin
        gen_cnt++;
      end
    end else begin
      gen_cnt = 0;
    end
    if (inj_rise || inj_fall) begin
      bus.spi_rise = bus.spi_rise | inj_rise;
      bus.spi_fall = bus.spi_fall | inj_fall;
      inj_active   = 1'b1;
      inj_rise     = 1'b0;
      inj_fall     = 1'b0;
    end
  endtask

  task automatic start_xfer(input logic [31:0] data, input int lm1, input int mode, input int div);
    gen_div          = div;
    sdi_mode         = mode;
    sdi_word         = $urandom;
    cur_lm1          = lm1;
    rise_cnt         = 0;
    trail_cnt        = 0;
    sdo_word         = '0;
    en_after_last    = 1'b1;
    sdo_before_trail = 1'b0;
    sdo_after_trail  = 1'b0;
    rxv_after_trail  = 1'b0;
    bus.tx_data      = data;
    bus.len_m1       = LW'(lm1);
    bus.tx_valid     = 1'b1;
    for (int i = 0; i < 50 && !bus.tx_ready; i++) tick();
    check("tx_ready_wait", {31'd0, bus.tx_ready}, 32'd1);
    tick();
    bus.tx_valid = 1'b0;
    check("first_bit_clk_en_sdo", {30'd0, bus.clk_en, bus.sdo}, {30'd0, 1'b1, data[lm1]});
  endtask

  task automatic wait_rx();
    for (int i = 0; i < 3000 && !bus.rx_valid; i++) tick();
    check("rx_valid_wait", {31'd0, bus.rx_valid}, 32'd1);
  endtask

  task automatic check_result(input logic [31:0] data, input int lm1, input logic [31:0] exp_rx);
    logic [31:0] mask;
    mask = (lm1 == 31) ? 32'hFFFF_FFFF : ((32'd1 << (lm1 + 1)) - 32'd1);
    $display("xfer tx=%08h len=%0d rx=%08h exp=%08h rises=%0d", data, lm1 + 1, bus.rx_data, exp_rx, rise_cnt);
    check("rx_data", bus.rx_data, exp_rx);
    check("rise_count", rise_cnt, lm1 + 1);
    check("sdo_sequence", sdo_word, data & mask);
    check("clk_en_after_last_rise", {31'd0, en_after_last}, 32'd0);
    check("trailing_falls", trail_cnt, 32'd1);
    check("sdo_stable_trailing", {31'd0, sdo_after_trail}, {31'd0, sdo_before_trail});
    check("rx_valid_after_trailing", {31'd0, rxv_after_trail}, 32'd1);
  endtask

  task automatic accept();
    bus.rx_ready = 1'b1;
    tick();
    bus.rx_ready = 1'b0;
    check("idle_after_accept", {28'd0, bus.tx_ready, bus.busy, bus.sdo, bus.rx_valid}, 32'b1000);
  endtask

  initial begin
    logic [31:0] rxd, d, mask;
    int lm1, dv, viol;

    rst          = 1'b1;
    bus.tx_data  = '0;
    bus.len_m1   = '0;
    bus.tx_valid = 1'b0;
    bus.rx_ready = 1'b0;
    bus.spi_rise = 1'b0;
    bus.spi_fall = 1'b0;
    bus.sdi      = 1'b0;
    tick();
    tick();
    check("reset_flags", {26'd0, bus.tx_ready, bus.rx_valid, bus.clk_en, bus.sdo, bus.busy, 1'b0}, 32'b100000);
    check("reset_rx_data", bus.rx_data, 32'd0);
    rst = 1'b0;
    tick();

    // Directed table
    vecs[0] = '{32'h0000_00A5, 7,  2, 1, 32'h0000_00A5};
    vecs[1] = '{32'hDEAD_BEEF, 31, 1, 1, 32'hFFFF_FFFF};
    vecs[2] = '{32'h0000_0001, 0,  0, 1, 32'h0000_0000};
    vecs[3] = '{32'h0000_3C96, 15, 2, 3, 32'h0000_3C96};
    vecs[4] = '{32'hFFFF_FFFF, 4,  0, 2, 32'h0000_0000};
    for (int v = 0; v < 5; v++) begin
      start_xfer(vecs[v].data, vecs[v].lm1, vecs[v].mode, vecs[v].div);
      wait_rx();
      check_result(vecs[v].data, vecs[v].lm1, vecs[v].exp_rx);
      accept();
      tick();
    end

    // Randomised transfers against the word-level model
    for (int n = 0; n < 20; n++) begin
      d   = $urandom;
      lm1 = $urandom_range(0, 31);
      dv  = $urandom_range(1, 3);
      start_xfer(d, lm1, 3, dv);
      mask = (lm1 == 31) ? 32'hFFFF_FFFF : ((32'd1 << (lm1 + 1)) - 32'd1);
      wait_rx();
      check_result(d, lm1, sdi_word & mask);
      accept();
      tick();
    end

    // Backpressure: result held, next word waits, stray strobes ignored
    start_xfer(32'h5A, 7, 2, 1);
    wait_rx();
    rxd = bus.rx_data;
    check("stall_rx_data", rxd, 32'h5A);
    bus.tx_data  = 32'hF0;
    bus.len_m1   = LW'(7);
    bus.tx_valid = 1'b1;
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) inj_rise = 1'b1;
      else inj_fall = 1'b1;
      bus.sdi = ~bus.sdi;
      tick();
      if (bus.rx_valid !== 1'b1 || bus.rx_data !== rxd || bus.tx_ready !== 1'b0 || bus.clk_en !== 1'b0)
        viol++;
    end
    check("stall_violations", viol, 32'd0);
    accept();
    start_xfer(32'hF0, 7, 2, 1);
    wait_rx();
    check_result(32'hF0, 7, 32'hF0);
    accept();
    tick();

    // Reset after the third rise of an 8-bit transfer
    start_xfer(32'hC3, 7, 2, 1);
    for (int i = 0; i < 100 && rise_cnt < 3; i++) tick();
    tick();
    rst = 1'b1;
    tick();
    check("midreset_flags", {27'd0, bus.clk_en, bus.tx_ready, bus.rx_valid, bus.sdo, bus.busy}, 32'b01000);
    rst = 1'b0;
    viol = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.rx_valid !== 1'b0 || bus.busy !== 1'b0) viol++;
    end
    check("midreset_quiet", viol, 32'd0);

    // Injected rise during DRAIN must not disturb the received word
    start_xfer(32'h9, 3, 1, 4);
    for (int i = 0; i < 200 && !(rise_cnt == 4 && bus.busy && !bus.clk_en && !bus.rx_valid); i++) tick();
    check("reached_drain", {30'd0, bus.busy, bus.clk_en}, 32'b10);
    inj_rise = 1'b1;
    tick();
    wait_rx();
    check_result(32'h9, 3, 32'hF);
    accept();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
